cordic_arbiter: RTL

- Round-robin arbiter and sequencer sharing one pipelined CORDIC rotation core between NREQ requesters.
- Accepts (angle, x, y) requests through valid/ready handshakes and issues at most one per cycle into the core.
- Tracks each in-flight operation with a tag shift register matched to the core latency.
- Returns each core result with the originating requester id; a per-requester outstanding-credit counter limits in-flight work.

---
 rtl/cordic_arbiter_if.sv | 40 ++++
 rtl/cordic_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/cordic_arbiter_if.sv
// Bundle of the request, core-side and response signals of cordic_arbiter.
// The arbiter uses the slave modport; requesters, the CORDIC core and the
// response sink sit behind the master modport.
//
// Handshake: a request from requester i transfers on a rising clock edge
// where req_valid[i] and req_ready[i] are both high. req_ready may be
// combinational on req_valid. rsp_valid is a one-cycle pulse with no
// backpressure, so the response sink must accept it.
interface cordic_arbiter_if #(
  parameter int NREQ    = 4,
  parameter int XY_SIZE = 8
);
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [32*NREQ-1:0]      req_angle;
  logic [XY_SIZE*NREQ-1:0] req_x;
  logic [XY_SIZE*NREQ-1:0] req_y;
  logic [31:0]             core_angle;
  logic [XY_SIZE-1:0]      core_xin;
  logic [XY_SIZE-1:0]      core_yin;
  logic [XY_SIZE:0]        core_xout;
  logic [XY_SIZE:0]        core_yout;
  logic                    rsp_valid;
  logic [2:0]              rsp_id;
  logic [XY_SIZE:0]        rsp_x;
  logic [XY_SIZE:0]        rsp_y;
  logic                    busy;

  modport slave (
    input  req_valid, req_angle, req_x, req_y, core_xout, core_yout,
    output req_ready, core_angle, core_xin, core_yin,
           rsp_valid, rsp_id, rsp_x, rsp_y, busy
  );

  modport master (
    output req_valid, req_angle, req_x, req_y, core_xout, core_yout,
    input  req_ready, core_angle, core_xin, core_yin,
           rsp_valid, rsp_id, rsp_x, rsp_y, busy
  );
endinterface

// File: rtl/cordic_arbiter.sv
// Round-robin arbiter feeding one pipelined CORDIC rotation core from NREQ
// requesters. A tag shift register follows each issued operation through
// the core so the result can be returned with its requester id, and a
// per-requester credit counter bounds the work each requester has in flight.
module cordic_arbiter #(
  parameter int NREQ    = 4,
  parameter int XY_SIZE = 8,
  parameter int LATENCY = 8,
  parameter int MAX_OUT = 4
) (
  input  logic             clock,
  input  logic             resetn,
  cordic_arbiter_if.slave  bus
);

  typedef struct packed {
    logic       vld;
    logic [2:0] id;
  } tag_t;

  logic [7:0]         elig;
  logic               win_valid;
  logic [2:0]         win_id;
  int                 win_sel;
  int                 idx;
  logic [NREQ-1:0]    inc;
  logic [NREQ-1:0]    dec;
  logic               any_tag;
  logic               any_cnt;

  logic [2:0]         rr_q, rr_d;
  logic [3:0]         cnt_q [NREQ];
  logic [3:0]         cnt_d [NREQ];
  tag_t               tag_q [LATENCY+1];
  tag_t               tag_d [LATENCY+1];
  logic [31:0]        core_angle_q, core_angle_d;
  logic [XY_SIZE-1:0] core_xin_q, core_xin_d;
  logic [XY_SIZE-1:0] core_yin_q, core_yin_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [2:0]         rsp_id_q, rsp_id_d;
  logic [XY_SIZE:0]   rsp_x_q, rsp_x_d;
  logic [XY_SIZE:0]   rsp_y_q, rsp_y_d;

  // Round-robin search: first eligible requester at or after rr, wrapping.
  always_comb begin
    elig      = '0;
    win_valid = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = bus.req_valid[i] && (cnt_q[i] < 4'(MAX_OUT));
    end
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_valid && elig[idx[2:0]]) begin
        win_valid = 1'b1;
        win_id    = idx[2:0];
      end
    end
    // No grant may be offered while reset is held.
    if (!resetn) win_valid = 1'b0;
  end

  // Per-requester grant and credit bookkeeping; a returning credit is not
  // bypassed to the same cycle's eligibility.
  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < NREQ; i++) begin
      inc[i]   = win_valid && (win_id == 3'(i));
      dec[i]   = rsp_valid_q && (rsp_id_q == 3'(i));
      cnt_d[i] = cnt_q[i] + {3'b000, inc[i]} - {3'b000, dec[i]};
    end
  end

  // Pointer update, issue register load and tag pipeline advance.
  always_comb begin
    win_sel      = int'(win_id);
    rr_d         = rr_q;
    core_angle_d = core_angle_q;
    core_xin_d   = core_xin_q;
    core_yin_d   = core_yin_q;
    tag_d[0]     = {win_valid, win_id};
    if (win_valid) begin
      rr_d         = (win_id == 3'(NREQ-1)) ? 3'd0 : win_id + 3'd1;
      core_angle_d = bus.req_angle[win_sel*32 +: 32];
      core_xin_d   = bus.req_x[win_sel*XY_SIZE +: XY_SIZE];
      core_yin_d   = bus.req_y[win_sel*XY_SIZE +: XY_SIZE];
    end
    for (int s = 1; s <= LATENCY; s++) begin
      tag_d[s] = tag_q[s-1];
    end
  end

  // Capture the core result when the final tag marks a live operation.
  always_comb begin
    rsp_valid_d = tag_q[LATENCY].vld;
    rsp_id_d    = rsp_id_q;
    rsp_x_d     = rsp_x_q;
    rsp_y_d     = rsp_y_q;
    if (tag_q[LATENCY].vld) begin
      rsp_id_d = tag_q[LATENCY].id;
      rsp_x_d  = bus.core_xout;
      rsp_y_d  = bus.core_yout;
    end
  end

  // Busy while anything is in the core, in the response register or owed.
  always_comb begin
    any_tag = 1'b0;
    any_cnt = 1'b0;
    for (int s = 0; s <= LATENCY; s++) begin
      any_tag = any_tag | tag_q[s].vld;
    end
    for (int i = 0; i < NREQ; i++) begin
      any_cnt = any_cnt | (cnt_q[i] != 4'd0);
    end
  end

  // State registers; reset drops all in-flight work without responses.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      rr_q         <= '0;
      core_angle_q <= '0;
      core_xin_q   <= '0;
      core_yin_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_x_q      <= '0;
      rsp_y_q      <= '0;
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
      for (int s = 0; s <= LATENCY; s++) tag_q[s] <= '0;
    end else begin
      rr_q         <= rr_d;
      core_angle_q <= core_angle_d;
      core_xin_q   <= core_xin_d;
      core_yin_q   <= core_yin_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_x_q      <= rsp_x_d;
      rsp_y_q      <= rsp_y_d;
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
      for (int s = 0; s <= LATENCY; s++) tag_q[s] <= tag_d[s];
    end
  end

  // A response can only return a credit that was actually taken.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NREQ; i++) begin
      if (resetn && dec[i]) assert (cnt_q[i] != 4'd0);
    end
  end

  assign bus.req_ready  = inc;
  assign bus.core_angle = core_angle_q;
  assign bus.core_xin   = core_xin_q;
  assign bus.core_yin   = core_yin_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_x      = rsp_x_q;
  assign bus.rsp_y      = rsp_y_q;
  assign bus.busy       = any_tag | rsp_valid_q | any_cnt;

endmodule
